// File: rtl/lcd_write_sequencer.sv
// HD44780 4-bit write engine: power-up delay, fixed init sequence, then
// command/data bytes split into two timed enable strobes with busy waits.
// Optional build macro: LCD_FIFO_EN adds a 4-entry write FIFO in front of
// the engine; without it the engine handshakes directly with the requester.
module lcd_write_sequencer #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_PULSE   = 25,
  parameter int unsigned T_WAIT    = 2000,
  parameter int unsigned T_CLR     = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [3:0] lcd_d
);

  localparam logic [19:0] C_PWR   = 20'(T_POWERUP);
  localparam logic [19:0] C_PULSE = 20'(T_PULSE);
  localparam logic [19:0] C_WAIT  = 20'(T_WAIT);
  localparam logic [19:0] C_CLR   = 20'(T_CLR);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        init_q, init_d;
  logic        low_q, low_d;
  logic        rs_q, rs_d;
  logic [3:0]  nib_q, nib_d;
  logic [7:0]  byte_q, byte_d;

  logic        eng_valid;
  logic        eng_rs;
  logic [7:0]  eng_data;
  logic        accept;
  logic [19:0] wait_sel;

  // Init items 0..3 are single nibbles (low 4 bits), 4..7 are full bytes.
  function automatic logic [7:0] init_item(input logic [2:0] s);
    case (s)
      3'd0, 3'd1, 3'd2: return 8'h03;
      3'd3:             return 8'h02;
      3'd4:             return 8'h28;
      3'd5:             return 8'h0C;
      3'd6:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && init_q && eng_valid;

`ifdef LCD_FIFO_EN
  logic [8:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] count_q;
  logic       push;

  assign push      = in_valid && in_ready;
  assign in_ready  = init_q && (count_q != 3'd4);
  assign eng_valid = (count_q != 3'd0);
  assign eng_rs    = mem_q[rd_q][8];
  assign eng_data  = mem_q[rd_q][7:0];

  // FIFO storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_rs, in_data};
  end

  // FIFO pointers and occupancy; pop happens on the engine accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      if (push)   wr_q <= wr_q + 2'd1;
      if (accept) rd_q <= rd_q + 2'd1;
      count_q <= count_q + {2'b0, push} - {2'b0, accept};
    end
  end
`else
  assign in_ready  = (state_q == S_IDLE) && init_q;
  assign eng_valid = in_valid;
  assign eng_rs    = in_rs;
  assign eng_data  = in_data;
`endif

  // Early init nibbles have fixed waits; bytes use clear/home detection.
  always_comb begin
    wait_sel = C_WAIT;
    if (!init_q && !step_q[2])
      wait_sel = step_q[1] ? C_WAIT : C_CLR;
    else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
      wait_sel = C_CLR;
  end

  // State register with synchronous reset back to the power-up delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWRUP;
      cnt_q   <= C_PWR;
      step_q  <= 3'd0;
      init_q  <= 1'b0;
      low_q   <= 1'b0;
      rs_q    <= 1'b0;
      nib_q   <= 4'h0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      init_q  <= init_d;
      low_q   <= low_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic; the shared counter times whichever state is active.
  always_comb begin
    logic       do_launch;
    logic [2:0] launch_step;
    logic [7:0] item;
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    init_d      = init_q;
    low_d       = low_q;
    rs_d        = rs_q;
    nib_d       = nib_q;
    byte_d      = byte_q;
    do_launch   = 1'b0;
    launch_step = 3'd0;
    item        = 8'h00;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == 20'd1) do_launch = 1'b1;
        else cnt_d = cnt_q - 20'd1;
      end
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          rs_d    = eng_rs;
          byte_d  = eng_data;
          nib_d   = eng_data[7:4];
          low_d   = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = C_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == 20'd1) state_d = S_HOLD;
        else cnt_d = cnt_q - 20'd1;
      end
      S_HOLD: begin
        if (low_q) begin
          state_d = S_WAIT;
          cnt_d   = wait_sel;
        end else begin
          state_d = S_GAP;
          cnt_d   = C_PULSE;
        end
      end
      S_GAP: begin
        if (cnt_q == 20'd1) begin
          state_d = S_SETUP;
          nib_d   = byte_q[3:0];
          low_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 20'd1) begin
          cnt_d = cnt_q - 20'd1;
        end else if (init_q) begin
          state_d = S_IDLE;
        end else if (step_q == 3'd7) begin
          state_d = S_IDLE;
          init_d  = 1'b1;
        end else begin
          do_launch   = 1'b1;
          launch_step = step_q + 3'd1;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = C_PWR;
      end
    endcase
    if (do_launch) begin
      item    = init_item(launch_step);
      state_d = S_SETUP;
      step_d  = launch_step;
      rs_d    = 1'b0;
      byte_d  = item;
      if (!launch_step[2]) begin
        nib_d = item[3:0];
        low_d = 1'b1;
      end else begin
        nib_d = item[7:4];
        low_d = 1'b0;
      end
    end
  end

  assign init_done = init_q;
  assign lcd_en    = (state_q == S_PULSE);
  assign lcd_rs    = rs_q;
  assign lcd_d     = nib_q;
  assign lcd_rw    = 1'b0;

endmodule
